// File: rtl/rptr_empty_fwft_if.sv
// rptr_empty_fwft_if: FWFT output stream between the FIFO read side and its consumer
interface rptr_empty_fwft_if #(
    parameter int data_size = 8
);
    logic [data_size-1:0] dout;
    logic dout_valid;
    logic dout_ready;
    modport master(output dout, dout_valid, input dout_ready);
    modport slave(input dout, dout_valid, output dout_ready);
endinterface

// File: rtl/rptr_empty_fwft.sv
// rptr_empty_fwft: async FIFO read-side pointers, empty/count flags and 2-deep FWFT output stage
module rptr_empty_fwft #(
    parameter int add_size = 4,
    parameter int data_size = 8,
    parameter int ae_level = 2
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic [add_size:0]    wr_ptr_sync,
    output logic [add_size-1:0]  rd_addr,
    output logic [add_size:0]    rd_ptr,
    output logic                 empty,
    output logic                 mem_rd_en,
    input  logic [data_size-1:0] mem_rd_data,
    output logic [add_size:0]    rd_count,
    output logic                 almost_empty,
    rptr_empty_fwft_if.master    s
);
    logic [add_size:0] rbin, rbin_next, rgray_next, wbin_s;
    logic [data_size-1:0] skid;
    logic skid_valid, pend, pop, head_free;
    logic [1:0] occ;
    // Gray to binary: each bit is the XOR of itself and every higher Gray bit
    for (genvar g = 0; g <= add_size; g++) begin : g_g2b
        assign wbin_s[g] = ^(wr_ptr_sync >> g);
    end
    assign occ = {1'b0, s.dout_valid} + {1'b0, skid_valid} + {1'b0, pend};
    assign pop = s.dout_valid & s.dout_ready;
    assign mem_rd_en = ~empty & ((occ - {1'b0, pop}) < 2'd2);
    assign head_free = ~s.dout_valid | pop;
    assign rbin_next = rbin + {{add_size{1'b0}}, mem_rd_en};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;
    assign rd_addr = rbin[add_size-1:0];
    assign almost_empty = rd_count <= (add_size+1)'(ae_level);
    always_ff @(posedge rd_clk or negedge rd_rst)
        if (!rd_rst) begin
            rbin <= '0;
            rd_ptr <= '0;
            empty <= 1'b1;
            rd_count <= '0;
            pend <= 1'b0;
            skid_valid <= 1'b0;
            skid <= '0;
            s.dout_valid <= 1'b0;
            s.dout <= '0;
        end else begin
            rbin <= rbin_next;
            rd_ptr <= rgray_next;
            empty <= rgray_next == wr_ptr_sync;
            rd_count <= wbin_s - rbin_next;
            pend <= mem_rd_en;
            // Skid always holds the word after dout, so it drains into the head first
            s.dout_valid <= (s.dout_valid & ~pop) | skid_valid | pend;
            s.dout <= head_free ? (skid_valid ? skid : pend ? mem_rd_data : s.dout) : s.dout;
            skid_valid <= head_free ? skid_valid & pend : skid_valid | pend;
            skid <= pend ? mem_rd_data : skid;
        end
endmodule

// File: tb/tb_rptr_empty_fwft.sv
// tb_rptr_empty_fwft: random-traffic check of the FIFO read side against a word-count/queue model
module tb_rptr_empty_fwft;
    logic rd_clk = 1'b0;
    logic rd_rst = 1'b0;
    logic [4:0] wr_ptr_sync = '0;
    logic [3:0] rd_addr;
    logic [4:0] rd_ptr, rd_count;
    logic empty, mem_rd_en, almost_empty;
    logic [7:0] mem_rd_data = '0;
    logic [7:0] mem [16];
    int vectors = 0;
    int miscompares = 0;
    int wcnt, wprev, nreads, npops;
    logic last_en;
    logic [7:0] q [$];

    rptr_empty_fwft_if #(.data_size(8)) s ();

    rptr_empty_fwft #(.add_size(4), .data_size(8), .ae_level(2)) dut (
        .rd_clk(rd_clk),
        .rd_rst(rd_rst),
        .wr_ptr_sync(wr_ptr_sync),
        .rd_addr(rd_addr),
        .rd_ptr(rd_ptr),
        .empty(empty),
        .mem_rd_en(mem_rd_en),
        .mem_rd_data(mem_rd_data),
        .rd_count(rd_count),
        .almost_empty(almost_empty),
        .s(s)
    );

    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk) if (mem_rd_en) mem_rd_data <= mem[rd_addr];

    function automatic logic [4:0] gray(input int n);
        logic [4:0] b;
        b = 5'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        wcnt = 0;
        wprev = 0;
        nreads = 0;
        npops = 0;
        last_en = 1'b0;
        q.delete();
    endtask

    // One clock: write up to nwr words, drive ready, check the cycle, then check registered state
    task automatic step(input logic rdy, input int nwr);
        int cnt, stage;
        logic dv, pop, en;
        @(negedge rd_clk);
        for (int k = 0; k < nwr; k++)
            if (wcnt - npops < 16) begin
                mem[wcnt % 16] = 8'($urandom);
                q.push_back(mem[wcnt % 16]);
                wcnt++;
            end
        wr_ptr_sync = gray(wcnt);
        s.dout_ready = rdy;
        #1;
        cnt = wprev - nreads;
        stage = nreads - npops;
        dv = (stage - int'(last_en)) > 0;
        pop = dv & rdy;
        en = (cnt != 0) && (stage - int'(pop) < 2);
        chk("dout_valid", 32'(s.dout_valid), 32'(dv));
        chk("mem_rd_en", 32'(mem_rd_en), 32'(en));
        if (pop) begin
            chk("dout", 32'(s.dout), 32'(q.pop_front()));
            npops++;
        end
        @(posedge rd_clk);
        #1;
        nreads += int'(en);
        last_en = en;
        wprev = wcnt;
        chk("rd_count", 32'(rd_count), 32'(wprev - nreads));
        chk("rd_ptr", 32'(rd_ptr), 32'(gray(nreads)));
        chk("rd_addr", 32'(rd_addr), 32'(nreads % 16));
        chk("empty", 32'(empty), 32'(wprev == nreads));
        chk("almost_empty", 32'(almost_empty), 32'((wprev - nreads) <= 2));
    endtask

    task automatic reset_checks();
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_rd_ptr", 32'(rd_ptr), 32'(0));
        chk("rst_rd_count", 32'(rd_count), 32'(0));
        chk("rst_dout_valid", 32'(s.dout_valid), 32'(0));
        chk("rst_almost_empty", 32'(almost_empty), 32'(1));
        chk("rst_mem_rd_en", 32'(mem_rd_en), 32'(0));
    endtask

    initial begin
        s.dout_ready = 1'b0;
        model_reset();
        #12;
        reset_checks();
        @(negedge rd_clk);
        rd_rst = 1'b1;
        // single word, then drain
        step(1'b1, 1);
        repeat (4) step(1'b1, 0);
        // backpressure: five words, stage fills to two and reads stop at rd_count=3
        step(1'b0, 5);
        repeat (4) step(1'b0, 0);
        repeat (8) step(1'b1, 0);
        // steady stream across the pointer wrap
        repeat (24) step(1'b1, 1);
        repeat (4) step(1'b1, 0);
        repeat (400) step(1'($urandom_range(0, 3) != 0), $urandom_range(0, 2));
        // asynchronous reset while both output registers hold words
        repeat (4) step(1'b1, 0);
        step(1'b0, 6);
        repeat (4) step(1'b0, 0);
        @(posedge rd_clk);
        #3;
        rd_rst = 1'b0;
        #1;
        reset_checks();
        model_reset();
        wr_ptr_sync = '0;
        repeat (2) @(negedge rd_clk);
        rd_rst = 1'b1;
        repeat (3) step(1'b1, 0);
        repeat (300) step(1'($urandom_range(0, 1)), $urandom_range(0, 3));
        repeat (30) step(1'b1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
